// File: rtl/fetch_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// fetch_pkg : fetch entry layout and align mode, shared by fetch and decode.
// Revision  : 1.0 - initial release
// ----------------------------------------------------------------------------
package fetch_pkg;

  localparam int unsigned c_ENTRY_W = 66;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
    logic        is_comp;
    logic        err;
  } fetch_entry_t;

  typedef enum logic [0:0] {
    ALIGN_RUN      = 1'b0,
    ALIGN_ERR_WAIT = 1'b1
  } align_mode_e;

  function automatic logic is_comp_hw(input logic [15:0] hw);
    return hw[1:0] != 2'b11;
  endfunction

endpackage
`default_nettype wire

// File: rtl/fetch_align.sv
`default_nettype none
// ----------------------------------------------------------------------------
// fetch_align : splits a 32-bit fetch stream into up to two aligned entries.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
module fetch_align
  import fetch_pkg::*;
#(
  parameter logic [31:0] BootAddr = 32'h0000_0000
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic         flush_i,
  input  logic [31:0]  flush_pc_i,
  input  logic         fetch_valid_i,
  input  logic [31:0]  fetch_data_i,
  input  logic         fetch_err_i,
  output logic         fetch_rdy_o,
  output logic [1:0]   out_valid_o,
  output fetch_entry_t out_entry0_o,
  output fetch_entry_t out_entry1_o,
  input  logic [1:0]   out_rdy_i
);

  logic [31:0] r_pc;
  logic [15:0] r_hw;
  logic        r_hw_vld;
  logic        r_off;
  align_mode_e r_mode;

  logic        w_c0, w_c1, w_comp0, w_tail, w_active, w_e0_comp, w_all;
  logic [31:0] w_ins0, w_ins1, w_adv;
  logic [15:0] w_tail_hw;
  logic [1:0]  w_n_xfer, w_n_cmp;

  // Parse the halfword window into complete instructions plus a trailing start.
  always_comb begin
    w_c0      = 1'b0;
    w_c1      = 1'b0;
    w_comp0   = 1'b0;
    w_tail    = 1'b0;
    w_ins0    = fetch_data_i;
    w_ins1    = {16'h0000, fetch_data_i[31:16]};
    w_tail_hw = fetch_data_i[31:16];
    if (r_hw_vld) begin
      w_c0   = 1'b1;
      w_ins0 = {fetch_data_i[15:0], r_hw};
      w_c1   = is_comp_hw(fetch_data_i[31:16]);
      w_tail = ~w_c1;
    end else if (r_off) begin
      w_c0    = is_comp_hw(fetch_data_i[31:16]);
      w_comp0 = 1'b1;
      w_ins0  = {16'h0000, fetch_data_i[31:16]};
      w_tail  = ~w_c0;
    end else if (is_comp_hw(fetch_data_i[15:0])) begin
      w_c0    = 1'b1;
      w_comp0 = 1'b1;
      w_ins0  = {16'h0000, fetch_data_i[15:0]};
      w_c1    = is_comp_hw(fetch_data_i[31:16]);
      w_tail  = ~w_c1;
    end else begin
      w_c0 = 1'b1;
    end
  end

  assign w_active  = fetch_valid_i & ~flush_i & (r_mode == ALIGN_RUN);
  assign w_e0_comp = ~fetch_err_i & w_comp0;

  always_comb begin
    out_valid_o = 2'b00;
    if (w_active) out_valid_o = fetch_err_i ? 2'b01 : {w_c1, w_c0};
  end

  assign out_entry0_o = '{instr:   fetch_err_i ? fetch_data_i : w_ins0,
                          pc:      r_pc,
                          is_comp: w_e0_comp,
                          err:     fetch_err_i};
  assign out_entry1_o = '{instr:   w_ins1,
                          pc:      r_pc + (w_e0_comp ? 32'd2 : 32'd4),
                          is_comp: 1'b1,
                          err:     1'b0};

  always_comb begin
    w_n_xfer = 2'd0;
    if (out_valid_o == 2'b11 && out_rdy_i == 2'b11) w_n_xfer = 2'd2;
    else if (out_valid_o[0] & out_rdy_i[0])         w_n_xfer = 2'd1;
  end

  assign w_n_cmp     = {1'b0, out_valid_o[0]} + {1'b0, out_valid_o[1]};
  assign w_all       = (w_n_xfer == w_n_cmp);
  assign fetch_rdy_o = flush_i | (r_mode == ALIGN_ERR_WAIT) | (fetch_valid_i & w_all);
  assign w_adv       = ((w_n_xfer != 2'd0) ? (w_e0_comp ? 32'd2 : 32'd4) : 32'd0)
                     + ((w_n_xfer == 2'd2) ? 32'd2 : 32'd0);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_pc     <= BootAddr;
      r_hw     <= 16'h0000;
      r_hw_vld <= 1'b0;
      r_off    <= BootAddr[1];
      r_mode   <= ALIGN_RUN;
    end else if (flush_i) begin
      r_pc     <= flush_pc_i & ~32'h1;
      r_off    <= flush_pc_i[1];
      r_hw_vld <= 1'b0;
      r_mode   <= ALIGN_RUN;
    end else if (r_mode == ALIGN_RUN && fetch_valid_i) begin
      if (fetch_err_i) begin
        if (w_n_xfer != 2'd0) begin
          r_mode   <= ALIGN_ERR_WAIT;
          r_hw_vld <= 1'b0;
          r_off    <= 1'b0;
        end
      end else begin
        r_pc <= r_pc + w_adv;
        if (w_all) begin
          r_off    <= 1'b0;
          r_hw_vld <= w_tail;
          if (w_tail) r_hw <= w_tail_hw;
        end else if (w_n_xfer != 2'd0) begin
          // Only entry0 left: the word's remaining work is its upper halfword.
          r_hw_vld <= 1'b0;
          r_off    <= 1'b1;
        end
      end
    end
  end

endmodule
`default_nettype wire

// File: doc/fetch_align.md
FETCH_ALIGN -- requirements
Module: fetch_align

Interface
REQ-001 Parameter: BootAddr, 32'h0000_0000, PC of first instruction after reset.
REQ-002 clk_i  input  1  clock; all state updates on rising edge.
REQ-003 rst_ni  input  1  reset, asynchronous, active-low.
REQ-004 flush_i  input  1  synchronous redirect; discards all buffered state.
REQ-005 flush_pc_i  input  32  redirect target; bit 0 ignored.
REQ-006 fetch_valid_i  input  1  sequential 32-bit fetch word available.
REQ-007 fetch_data_i  input  32  fetch word, word-aligned, little-endian halfwords.
REQ-008 fetch_err_i  input  1  bus error on this word.
REQ-009 fetch_rdy_o  output  1  fetch word consumed this cycle when fetch_valid_i & fetch_rdy_o.
REQ-010 out_valid_o  output  2  instructions offered: 2'b00, 2'b01 or 2'b11 only; drives dual_fifo wr_valid_i.
REQ-011 out_entry0_o / out_entry1_o  output  fetch_entry_t each  {instr[31:0], pc[31:0], is_comp, err}, oldest in entry0.
REQ-012 out_rdy_i  input  2  downstream room (dual_fifo wr_rdy_o), encoding as out_valid_o.

Function
REQ-013 State: pc_q (PC of oldest unissued instruction), hw_q[15:0]+hw_vld_q (low half of a split 32-bit instruction), off_q (held word's low halfword already used), mode RUN/ERR_WAIT.
REQ-014 Window: hw_vld_q -> {fetch_data_i, hw_q}; else off_q -> fetch_data_i[31:16]; else fetch_data_i.
REQ-015 Halfword with [1:0]!=2'b11 is compressed (16-bit, zero-extended into instr, is_comp=1); otherwise starts a 32-bit instruction.
REQ-016 Window parses 0, 1 or 2 complete instructions; trailing incomplete 32-bit start is stored to hw_q on word acceptance; hw_q never holds a compressed instruction.
REQ-017 out_valid_o SHALL depend only on state, fetch_valid_i, fetch_data_i, fetch_err_i and flush_i, never on out_rdy_i.
REQ-018 Transfers: 2 if out_valid_o==2'b11 and out_rdy_i==2'b11; else 1 if out_valid_o[0]&out_rdy_i[0]; else 0.
REQ-019 fetch_rdy_o=1 when all complete instructions in the window transfer this cycle (including 0 complete) or during flush_i/ERR_WAIT.
REQ-020 Partial transfer (2 offered, 1 taken): word not consumed; entry0 retired by clearing hw_vld_q or setting off_q.
REQ-021 Word consumption clears off_q.
REQ-022 entry1.pc = entry0.pc + (entry0.is_comp ? 2 : 4); pc_q advances by total size transferred, modulo 2^32.
REQ-023 fetch_err_i word in RUN: emit exactly one entry (out_valid_o=2'b01, err=1, pc=pc_q, instr=fetch_data_i, is_comp=0); on transfer consume word, enter ERR_WAIT.
REQ-024 ERR_WAIT: out_valid_o=2'b00, fetch words consumed and dropped until flush_i.
REQ-025 flush_i (priority over all): out_valid_o=2'b00, fetch_rdy_o=1, fetch word dropped; next pc_q=flush_pc_i&~1, off_q=flush_pc_i[1], hw_vld_q=0, mode RUN.
REQ-026 Entry fields not covered by out_valid_o are don't-care but SHALL be X-free.

Reset
REQ-027 On rst_ni low: pc_q=BootAddr, hw_vld_q=0, hw_q=0, off_q=BootAddr[1], mode RUN.
REQ-028 Outputs during/after reset: out_valid_o=2'b00 until a fetch word arrives; fetch_rdy_o=0 while fetch_valid_i=0.

Structure
REQ-029 Package fetch_pkg SHALL hold fetch_entry_t (66 bits) and the align mode enum; shared with decode.
REQ-030 Single module, no sub-module; output connects directly to a dual_fifo instance with Width=$bits(fetch_entry_t).

Verification
REQ-031 BootAddr=0x8000_0000, word 0x4505_4505, out_rdy_i=11 -> out_valid_o=11, pc0=0x8000_0000, pc1=0x8000_0002, both is_comp, fetch_rdy_o=1.
REQ-032 Words 0x0093_4505 then 0x4505_0010 -> cycle1 1 entry (0x4505); cycle2 entry0 instr=0x0010_0093 pc=0x8000_0002, entry1 instr=0x4505 pc=0x8000_0006.
REQ-033 Word 0x4505_4505, out_rdy_i=01 -> 1 transfer, fetch_rdy_o=0; next cycle out_valid_o=01, pc0=0x8000_0002; word consumed.
REQ-034 flush_i with flush_pc_i=0x8000_0102, then word 0x4505_FFFF -> single entry instr=0x4505 pc=0x8000_0102.
REQ-035 fetch_err_i=1 on word 3 -> one err entry, next words dropped with out_valid_o=00 until flush_i, then normal resume at flush_pc_i.
REQ-036 out_rdy_i=00 for 5 cycles with two entries offered -> outputs stable, fetch_rdy_o=0; dual_fifo level checks never overrun.
